// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the two requester ports, the data-memory port and
// the busy status of dm_arbiter.
//   slave  : arbiter side (takes requests and mem_rd, drives acks, mem_*, busy)
//   master : environment side (requesters plus memory model)
interface dm_arbiter_if;
  logic        p0_req,   p1_req;
  logic [31:0] p0_addr,  p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_we,    p1_we;
  logic [1:0]  p0_size,  p1_size;
  logic        p0_ack,   p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_err,   p1_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rd;
  logic        busy;

  modport slave (
    input  p0_req, p0_addr, p0_wdata, p0_we, p0_size,
    input  p1_req, p1_addr, p1_wdata, p1_we, p1_size,
    input  mem_rd,
    output p0_ack, p0_rdata, p0_err, p1_ack, p1_rdata, p1_err,
    output mem_addr, mem_wdata, mem_we, mem_byteen, busy
  );

  modport master (
    output p0_req, p0_addr, p0_wdata, p0_we, p0_size,
    output p1_req, p1_addr, p1_wdata, p1_we, p1_size,
    output mem_rd,
    input  p0_ack, p0_rdata, p0_err, p1_ack, p1_rdata, p1_err,
    input  mem_addr, mem_wdata, mem_we, mem_byteen, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter in front of a single
// word-wide data memory. Each access runs IDLE -> ACCESS -> DONE -> IDLE.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : dm_arbiter_if.slave (requester ports, memory port, busy)
// Parameter P0_FIRST selects which port wins the first simultaneous request.
module dm_arbiter #(
  parameter bit P0_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
  } cmd_t;

  // Pointer holds the port served last; resetting it to the *other* port
  // makes the P0_FIRST-selected port win the first tie.
  localparam logic LAST_RST = P0_FIRST ? 1'b1 : 1'b0;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        win_q, win_d;
  logic        last_q, last_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        grant, gnt_port, misaligned;
  logic [3:0]  byteen;
  logic [31:0] lane_wdata;

  // Arbitration: on a tie the port not served last wins.
  always_comb begin
    gnt_port = 1'b0;
    if (bus.p0_req && bus.p1_req) gnt_port = ~last_q;
    else if (bus.p1_req)          gnt_port = 1'b1;
  end
  assign grant = (state_q == IDLE) && (bus.p0_req || bus.p1_req);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, pointer and per-port read data
  always_comb begin
    cmd_d    = cmd_q;
    win_d    = win_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (grant) begin
      win_d  = gnt_port;
      last_d = gnt_port;
      cmd_d  = gnt_port ? cmd_t'{bus.p1_addr, bus.p1_wdata, bus.p1_we, bus.p1_size}
                        : cmd_t'{bus.p0_addr, bus.p0_wdata, bus.p0_we, bus.p0_size};
    end
    // Raw word is returned; lane extraction is left to the requester.
    if (state_q == ACCESS && !cmd_q.we) begin
      if (win_q) rdata1_d = bus.mem_rd;
      else       rdata0_d = bus.mem_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q    <= '0;
      win_q    <= 1'b0;
      last_q   <= LAST_RST;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      cmd_q    <= cmd_d;
      win_q    <= win_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Alignment check, byte enables and lane replication from the latched command
  always_comb begin
    misaligned = 1'b0;
    byteen     = 4'b0000;
    lane_wdata = cmd_q.wdata;
    case (cmd_q.size)
      2'd0: begin
        byteen     = 4'b0001 << cmd_q.addr[1:0];
        lane_wdata = {4{cmd_q.wdata[7:0]}};
      end
      2'd1: begin
        misaligned = cmd_q.addr[0];
        byteen     = cmd_q.addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{cmd_q.wdata[15:0]}};
      end
      2'd2: begin
        misaligned = (cmd_q.addr[1:0] != 2'b00);
        byteen     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    if (misaligned) byteen = 4'b0000;
  end

  // Outputs: memory port only live in ACCESS, acks only in DONE. All are
  // decoded from state_q so reset silences them immediately.
  always_comb begin
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = 1'b0;
    bus.mem_byteen = 4'b0000;
    bus.p0_ack     = 1'b0;
    bus.p1_ack     = 1'b0;
    bus.p0_err     = 1'b0;
    bus.p1_err     = 1'b0;
    bus.busy       = (state_q != IDLE);
    if (state_q == ACCESS) begin
      bus.mem_addr   = {cmd_q.addr[31:2], 2'b00};
      bus.mem_wdata  = lane_wdata;
      bus.mem_we     = cmd_q.we && !misaligned;
      bus.mem_byteen = byteen;
    end
    if (state_q == DONE) begin
      bus.p0_ack = ~win_q;
      bus.p1_ack =  win_q;
      bus.p0_err = ~win_q && misaligned;
      bus.p1_err =  win_q && misaligned;
    end
  end

  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a small
// byte-enabled memory behind the arbiter's memory port.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dm_arbiter_if bus();
  dm_arbiter #(.P0_FIRST(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Memory: combinational read, writes mid-cycle while mem_we is held.
  logic [31:0] mem [0:63];
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];
  always @(negedge clk) begin
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteen[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_p0(input logic req, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [1:0] sz);
    bus.p0_req = req; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_we = we; bus.p0_size = sz;
  endtask

  task automatic set_p1(input logic req, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [1:0] sz);
    bus.p1_req = req; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_we = we; bus.p1_size = sz;
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if ({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err} !== 4'b0) begin errors++; $display("FAIL rst_ack got %b exp 0000", {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}); end
    checks++; if ({bus.mem_we, bus.mem_byteen} !== 5'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 00000", {bus.mem_we, bus.mem_byteen}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", {bus.mem_addr, bus.mem_wdata}); end
    checks++; if ({bus.p0_rdata, bus.p1_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", {bus.p0_rdata, bus.p1_rdata}); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_req got busy %b exp 0", bus.busy); end
  endtask

  task automatic test_word_store;
    set_p0(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 2'd2);
    tick;
    checks++; if (bus.mem_addr !== 32'h10 || bus.mem_byteen !== 4'b1111 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL ws_access got addr %h be %b we %b exp 10 1111 1", bus.mem_addr, bus.mem_byteen, bus.mem_we); end
    checks++; if (bus.mem_wdata !== 32'hDEADBEEF || bus.busy !== 1'b1 || bus.p0_ack !== 1'b0) begin errors++; $display("FAIL ws_wdata got %h busy %b ack %b exp deadbeef 1 0", bus.mem_wdata, bus.busy, bus.p0_ack); end
    tick;
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b0 || bus.p1_ack !== 1'b0) begin errors++; $display("FAIL ws_ack got ack %b err %b p1 %b exp 1 0 0", bus.p0_ack, bus.p0_err, bus.p1_ack); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL ws_done_mem got we %b addr %h exp 0 0", bus.mem_we, bus.mem_addr); end
    bus.p0_req = 1'b0;
    tick;
    checks++; if (bus.busy !== 1'b0 || bus.p0_ack !== 1'b0) begin errors++; $display("FAIL ws_idle got busy %b ack %b exp 0 0", bus.busy, bus.p0_ack); end
  endtask

  task automatic test_byte_store;
    set_p1(1'b1, 32'h13, 32'h000000AB, 1'b1, 2'd0);
    tick;
    checks++; if (bus.mem_byteen !== 4'b1000 || bus.mem_wdata !== 32'hABABABAB || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL bs_access got be %b wd %h addr %h exp 1000 abababab 10", bus.mem_byteen, bus.mem_wdata, bus.mem_addr); end
    tick;
    checks++; if (bus.p1_ack !== 1'b1 || bus.p1_err !== 1'b0 || bus.p0_ack !== 1'b0) begin errors++; $display("FAIL bs_ack got p1 %b err %b p0 %b exp 1 0 0", bus.p1_ack, bus.p1_err, bus.p0_ack); end
    bus.p1_req = 1'b0;
    tick;
    set_p1(1'b1, 32'h10, 32'h0, 1'b0, 2'd2);
    tick;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_byteen !== 4'b1111) begin errors++; $display("FAIL bl_access got we %b be %b exp 0 1111", bus.mem_we, bus.mem_byteen); end
    tick;
    checks++; if (bus.p1_ack !== 1'b1 || bus.p1_rdata !== 32'hABADBEEF) begin errors++; $display("FAIL bl_rdata got ack %b rd %h exp 1 abadbeef", bus.p1_ack, bus.p1_rdata); end
    checks++; if (bus.p0_rdata !== 32'h0) begin errors++; $display("FAIL bl_p0_rdata_hold got %h exp 0", bus.p0_rdata); end
    bus.p1_req = 1'b0;
    tick;
  endtask

  task automatic test_misaligned;
    set_p0(1'b1, 32'h22, 32'h00001234, 1'b1, 2'd1);
    tick;
    checks++; if (bus.mem_byteen !== 4'b1100 || bus.mem_wdata !== 32'h12341234 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL hs_access got be %b wd %h we %b addr %h exp 1100 12341234 1 20", bus.mem_byteen, bus.mem_wdata, bus.mem_we, bus.mem_addr); end
    tick;
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b0) begin errors++; $display("FAIL hs_ack got ack %b err %b exp 1 0", bus.p0_ack, bus.p0_err); end
    bus.p0_req = 1'b0;
    tick;
    set_p0(1'b1, 32'h21, 32'h0, 1'b0, 2'd2);
    tick;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_byteen !== 4'b0000 || bus.mem_addr !== 32'h20) begin errors++; $display("FAIL mis_access got we %b be %b addr %h exp 0 0000 20", bus.mem_we, bus.mem_byteen, bus.mem_addr); end
    tick;
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b1 || bus.p1_err !== 1'b0) begin errors++; $display("FAIL mis_ack got ack %b err %b p1err %b exp 1 1 0", bus.p0_ack, bus.p0_err, bus.p1_err); end
    bus.p0_req = 1'b0;
    tick;
    set_p1(1'b1, 32'h0, 32'hFFFFFFFF, 1'b1, 2'd3);
    tick;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_byteen !== 4'b0000) begin errors++; $display("FAIL sz3_access got we %b be %b exp 0 0000", bus.mem_we, bus.mem_byteen); end
    tick;
    checks++; if ({bus.p1_ack, bus.p1_err, bus.p0_ack, bus.p0_err} !== 4'b1100) begin errors++; $display("FAIL sz3_ack got %b exp 1100", {bus.p1_ack, bus.p1_err, bus.p0_ack, bus.p0_err}); end
    bus.p1_req = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    reset = 1'b0;
    set_p0(1'b1, 32'h10, 32'h0, 1'b0, 2'd2);
    set_p1(1'b1, 32'h20, 32'h0, 1'b0, 2'd2);
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_in_reset got busy %b exp 0", bus.busy); end
    @(negedge clk) reset = 1'b1;
    // Grants land on edges 1,4,7,10: acks on 2(p0), 5(p1), 8(p0), 11(p1).
    for (int i = 1; i <= 12; i++) begin
      tick;
      checks++;
      if (bus.p0_ack !== (i == 2 || i == 8) || bus.p1_ack !== (i == 5 || i == 11) || bus.busy !== (i % 3 != 0)) begin
        errors++;
        $display("FAIL rr_cycle%0d got p0 %b p1 %b busy %b exp %b %b %b", i, bus.p0_ack, bus.p1_ack, bus.busy,
                 (i == 2 || i == 8), (i == 5 || i == 11), (i % 3 != 0));
      end
    end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    checks++; if (bus.p0_rdata !== 32'hABADBEEF || bus.p1_rdata !== 32'h12340000) begin errors++; $display("FAIL rr_rdata got %h %h exp abadbeef 12340000", bus.p0_rdata, bus.p1_rdata); end
    tick;
  endtask

  task automatic test_reset_mid_access;
    set_p1(1'b1, 32'h40, 32'h12345678, 1'b1, 2'd2);
    tick;
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rma_pre got we %b exp 1", bus.mem_we); end
    reset = 1'b0;
    #1;
    checks++; if ({bus.mem_we, bus.mem_byteen, bus.busy, bus.p1_ack} !== 7'b0) begin errors++; $display("FAIL rma_drop got %b exp 0000000", {bus.mem_we, bus.mem_byteen, bus.busy, bus.p1_ack}); end
    bus.p1_req = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (bus.p1_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rma_noack%0d got ack %b busy %b exp 0 0", i, bus.p1_ack, bus.busy); end
    end
    set_p0(1'b1, 32'h40, 32'h0, 1'b0, 2'd2);
    tick;
    tick;
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_rdata !== 32'h55AA55AA) begin errors++; $display("FAIL rma_mem got ack %b rd %h exp 1 55aa55aa", bus.p0_ack, bus.p0_rdata); end
    bus.p0_req = 1'b0;
    tick;
  endtask

  task automatic test_drop_req;
    set_p0(1'b1, 32'h10, 32'h0, 1'b0, 2'd2);
    tick;
    bus.p0_req = 1'b0;
    tick;
    checks++; if (bus.p0_ack !== 1'b1 || bus.p0_err !== 1'b0 || bus.p0_rdata !== 32'hABADBEEF) begin errors++; $display("FAIL drop_ack got ack %b err %b rd %h exp 1 0 abadbeef", bus.p0_ack, bus.p0_err, bus.p0_rdata); end
    tick;
    checks++; if (bus.busy !== 1'b0 || bus.p0_ack !== 1'b0) begin errors++; $display("FAIL drop_idle got busy %b ack %b exp 0 0", bus.busy, bus.p0_ack); end
    tick;
    checks++; if (bus.busy !== 1'b0 || bus.p0_rdata !== 32'hABADBEEF) begin errors++; $display("FAIL drop_hold got busy %b rd %h exp 0 abadbeef", bus.busy, bus.p0_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[16] = 32'h55AA55AA;
    set_p0(1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    set_p1(1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    test_reset;
    test_word_store;
    test_byte_store;
    test_misaligned;
    test_round_robin;
    test_reset_mid_access;
    test_drop_req;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter P0_FIRST, default 1: when 1, port 0 wins the first simultaneous request after reset; when 0, port 1 wins it.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pN_req  input  1  access request from requester N (N = 0, 1).
REQ-005 SHALL have ports pN_addr  input  32  byte address.
REQ-006 SHALL have ports pN_wdata  input  32  store data, right-aligned.
REQ-007 SHALL have ports pN_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have ports pN_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have ports pN_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports pN_rdata  output  32  raw memory word captured for a load.
REQ-011 SHALL have ports pN_err  output  1  misaligned or illegal-size flag, valid with pN_ack.
REQ-012 SHALL have port mem_addr  output  32  word address to the data memory, {addr[31:2], 2'b00}.
REQ-013 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_byteen  output  4  per-byte write enable.
REQ-016 SHALL have port mem_rd  input  32  combinational read word from the memory.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM IDLE -> ACCESS -> DONE -> IDLE, one cycle in each of ACCESS and DONE.
REQ-019 In IDLE with any pN_req high, SHALL latch the winner's addr, wdata, we and size, record the winner, and go to ACCESS.
REQ-020 In IDLE with no request, SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: with both requests high, grant the port not served last.
REQ-022 The last-served pointer SHALL reset so that the port selected by P0_FIRST wins first, and SHALL update on every grant.
REQ-023 In ACCESS, SHALL drive mem_addr, mem_wdata and mem_byteen from the latched command.
REQ-024 In ACCESS, mem_we SHALL equal the latched we AND NOT misaligned.
REQ-025 In ACCESS, SHALL register mem_rd into the winner's pN_rdata.
REQ-026 Outside ACCESS, mem_we, mem_byteen, mem_addr and mem_wdata SHALL be 0.
REQ-027 In DONE, SHALL assert the winner's pN_ack for exactly one cycle, with pN_err = misaligned, then go to IDLE.
REQ-028 Latency SHALL be: request sampled in IDLE at cycle t, memory driven in cycle t+1, ack in cycle t+2.
REQ-029 A port SHALL NOT be re-granted earlier than cycle t+3.
REQ-030 Byte enables SHALL be: byte -> 4'b0001 << addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
REQ-031 Store data lanes SHALL be: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-032 Misaligned SHALL mean: half with addr[0]=1, word with addr[1:0]!=0, or size 3.
REQ-033 A misaligned access SHALL drive mem_byteen = 0 and mem_we = 0, and SHALL still ack with err=1.
REQ-034 Loads SHALL return the full raw word; lane extraction and sign extension are the requester's job.
REQ-035 pN_rdata SHALL hold its value until that port's next load completes.
REQ-036 Requester protocol: hold pN_req and the command stable until ack, and deassert pN_req at the edge where ack is sampled.
REQ-037 If pN_req drops after the grant, the latched access SHALL still complete and ack.
REQ-038 A non-winning request SHALL wait without loss of any stall count.
REQ-039 No ack or err SHALL ever be generated for a port that was not granted.

Reset
REQ-040 reset low SHALL immediately force IDLE and clear the pointer per P0_FIRST.
REQ-041 reset low SHALL immediately force all pN_ack, pN_err, pN_rdata, mem_* outputs and busy to 0.
REQ-042 Reset asserted during ACCESS SHALL drop mem_we within the same cycle and SHALL produce no ack after release.
REQ-043 The first grant after reset release SHALL occur no earlier than the first rising edge with reset high.

Verification
REQ-044 p0 word store addr 0x10, wdata 0xDEADBEEF -> ACCESS cycle mem_addr 0x10, byteen 1111, mem_we=1; p0_ack 2 cycles after the request is sampled; err=0.
REQ-045 p1 byte store addr 0x13, wdata 0x000000AB -> byteen 1000, mem_wdata 0xABABABAB; a following word load of 0x10 returns 0xABADBEEF.
REQ-046 p0 and p1 request together continuously from reset, P0_FIRST=1 -> grant order p0, p1, p0, p1; each ack 3 cycles apart; no double acks.
REQ-047 p0 half store addr 0x22 -> byteen 1100; p0 word load addr 0x21 -> mem_we=0, byteen 0000, p0_ack with p0_err=1.
REQ-048 reset pulsed low during ACCESS of a p1 store -> mem_we falls immediately; no p1_ack; the store has no effect on subsequent reads.
REQ-049 p0 drops req one cycle after grant -> p0_ack is still issued in DONE, and the arbiter returns to IDLE.
